multi_sync_filter: RTL and testbench
====================================

Name: multi_sync_filter

Overview:
- Parametrised successor to the single-bit synchronizer/strobe logic.
- Brings CHANNELS asynchronous inputs (buttons, straps, slow external status lines) into the `clk` domain through a configurable flip-flop chain.
- Adds a per-channel glitch/debounce filter and registered rise/fall strobes.
- Sits between pad inputs and the USB/bootloader control logic; all outputs are glitch-free and one-clock strobes.

Parameters:
- CHANNELS, 4: number of independent input bits.
- SYNC_STAGES, 2: synchronizer flops per channel; minimum 2 (values <2 are a config error, elaboration must fail).
- FILTER_CYCLES, 4: consecutive mismatching samples required before the filtered level flips; 0 is treated as 1 (no filtering).
- RESET_LEVEL, 0: 1-bit value loaded into every sync flop and filtered level at reset.
- CNT_WIDTH, derived: clog2(FILTER_CYCLES+1), minimum 1; not to be overridden.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset; assert async, deassert is synchronous to clk in the top-level.
- data_in  in  CHANNELS  asynchronous raw inputs.
- level_out  out  CHANNELS  filtered, synchronized level per channel.
- rise_out  out  CHANNELS  one-clk strobe when level_out goes 0->1.
- fall_out  out  CHANNELS  one-clk strobe when level_out goes 1->0.
- change_out  out  1  OR of all rise_out|fall_out, same cycle.

Behaviour:
- Reset (reset_n low, immediate):
  - All sync flops = RESET_LEVEL.
  - level_out = {CHANNELS{RESET_LEVEL}}.
  - All counters = 0.
  - rise_out, fall_out and change_out = 0.
- Sync chain: per channel a shift register; stage 0 samples data_in[i] each clk edge. sync_q = stage SYNC_STAGES-1.
- Filter, per channel, evaluated each clk edge, in priority order:
  1. sync_q == level: cnt <= 0; no strobe.
  2. sync_q != level and cnt == max(FILTER_CYCLES,1)-1: level <= sync_q; cnt <= 0; rise or fall strobe registered in this same edge, so it is high in the same cycle as the new level.
  3. Otherwise: cnt <= cnt+1.
- Any single sample with sync_q == level restarts the count, so the mismatch must be observed on FILTER_CYCLES consecutive edges.
- Latency: a clean step on data_in set up before edge E1 appears on level_out after edge E(SYNC_STAGES+FILTER_CYCLES). Defaults: 6 clk.
- Strobes:
  - Exactly one cycle wide.
  - rise_out and fall_out are never both high for the same channel.
  - Consecutive strobes on a channel are separated by at least max(FILTER_CYCLES,1) cycles.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes; change_out is a single-cycle OR.
- Glitch rejection: a sync_q deviation lasting fewer than FILTER_CYCLES cycles never changes level_out and produces no strobe.
- Counter never exceeds FILTER_CYCLES-1; no wrap-around possible.
- Reset mid-count: counter and level are discarded immediately; after release, a held input differing from RESET_LEVEL produces a strobe after the full latency.
- All outputs are registered; no combinational path from data_in to any output.

Test Plan:
- Reset check (defaults): hold reset_n=0, data_in=4'hF → level_out=0, rise/fall/change=0. Release with data_in=4'hF → after 6 edges level_out=4'hF, rise_out=4'hF and change_out=1 for exactly 1 cycle, then both 0.
- Clean step latency (defaults): ch0 0->1 before edge 1 → level_out[0]=1 after edge 6, rise_out[0] pulse in that cycle only. 1->0 later → fall_out[0] pulse after 6 edges.
- Glitch rejection (FILTER_CYCLES=4): ch1 high for 3 clk then low → level_out[1] stays 0 with no strobe. Bounce pattern 1,1,1,0,1,1,1,1 → strobe only after the final 4 consecutive highs.
- Simultaneous/independent channels: ch0 rises while ch2 falls on the same edge (level_out[2] previously 1) → rise_out=4'b0001 and fall_out=4'b0100 in the same cycle, change_out=1 for 1 cycle.
- Reset mid-operation: assert reset_n after 2 filter counts of a ch3 rise → level_out[3]=0 immediately. Release with input still high → strobe 6 edges after release.
- Parameter sweep: SYNC_STAGES=3, FILTER_CYCLES=0, RESET_LEVEL=1. Input held low through reset → fall_out pulse 4 edges after release.

Source files
------------

// File: rtl/multi_sync_filter.sv
// Multi-channel pad-input synchronizer with per-channel debounce filter
// and registered one-clock rise/fall strobes.
module multi_sync_filter #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] data_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_out,
    output logic [CHANNELS-1:0] fall_out,
    output logic                change_out
);

    localparam int unsigned FILT_LEN  = (FILTER_CYCLES == 0) ? 1 : FILTER_CYCLES;
    localparam int unsigned CNT_RAW   = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned CNT_WIDTH = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(FILT_LEN - 1);

    if (SYNC_STAGES < 2) begin : g_bad_cfg
        $error("multi_sync_filter: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0][CHANNELS-1:0]  sync_q, sync_d;
    logic [CHANNELS-1:0][CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0]                   level_q, level_d;
    logic [CHANNELS-1:0]                   rise_q, rise_d;
    logic [CHANNELS-1:0]                   fall_q, fall_d;
    logic                                  change_q, change_d;
    logic [CHANNELS-1:0]                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Shift chain: stage 0 samples the raw pads.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = data_in;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Level flips only after FILT_LEN consecutive mismatching samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sync_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync_s[i];
                cnt_d[i]   = '0;
                rise_d[i]  = sync_s[i];
                fall_d[i]  = ~sync_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
        change_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= {(SYNC_STAGES*CHANNELS){RESET_LEVEL}};
            cnt_q    <= '0;
            level_q  <= {CHANNELS{RESET_LEVEL}};
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign level_out  = level_q;
    assign rise_out   = rise_q;
    assign fall_out   = fall_q;
    assign change_out = change_q;

endmodule

// File: tb/tb_multi_sync_filter.sv
// Directed bench for multi_sync_filter: default instance plus a
// SYNC_STAGES=3 / FILTER_CYCLES=0 / RESET_LEVEL=1 instance.
module tb_multi_sync_filter;

    logic       clk;
    logic       reset_n;
    logic       rst1_n;
    logic [3:0] data_in;
    logic [3:0] data_in1;
    logic [3:0] level_out, rise_out, fall_out;
    logic       change_out;
    logic [3:0] level_out1, rise_out1, fall_out1;
    logic       change_out1;

    int n_total;
    int n_bad;

    multi_sync_filter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .level_out  (level_out),
        .rise_out   (rise_out),
        .fall_out   (fall_out),
        .change_out (change_out)
    );

    multi_sync_filter #(
        .CHANNELS      (4),
        .SYNC_STAGES   (3),
        .FILTER_CYCLES (0),
        .RESET_LEVEL   (1'b1)
    ) dut1 (
        .clk        (clk),
        .reset_n    (rst1_n),
        .data_in    (data_in1),
        .level_out  (level_out1),
        .rise_out   (rise_out1),
        .fall_out   (fall_out1),
        .change_out (change_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] lvl, input logic [3:0] r,
                              input logic [3:0] f, input logic c);
        check_eq({tag, ".level"},  32'(level_out),  32'(lvl));
        check_eq({tag, ".rise"},   32'(rise_out),   32'(r));
        check_eq({tag, ".fall"},   32'(fall_out),   32'(f));
        check_eq({tag, ".change"}, 32'(change_out), 32'(c));
    endtask

    // Hold the current input for n edges; expect quiet outputs until the
    // last edge, where the given transition must appear.
    task automatic step_and_expect(input string tag, input int n, input logic [3:0] old_lvl,
                                   input logic [3:0] new_lvl, input logic [3:0] r,
                                   input logic [3:0] f);
        for (int k = 1; k < n; k++) begin
            tick();
            check_outs({tag, ".wait"}, old_lvl, 4'h0, 4'h0, 1'b0);
        end
        tick();
        check_outs({tag, ".edge"}, new_lvl, r, f, |(r | f));
        tick();
        check_outs({tag, ".after"}, new_lvl, 4'h0, 4'h0, 1'b0);
    endtask

    logic [7:0] bounce;

    initial begin
        n_total  = 0;
        n_bad    = 0;
        reset_n  = 1'b0;
        rst1_n   = 1'b0;
        data_in  = 4'hF;
        data_in1 = 4'h0;
        bounce   = 8'b1111_0111;

        // Reset state with all inputs high
        tick();
        tick();
        check_outs("reset", 4'h0, 4'h0, 4'h0, 1'b0);
        reset_n = 1'b1;
        step_and_expect("rst_release", 6, 4'h0, 4'hF, 4'hF, 4'h0);

        // All channels back low
        data_in = 4'h0;
        step_and_expect("all_fall", 6, 4'hF, 4'h0, 4'h0, 4'hF);

        // Clean step on ch0, both directions
        data_in = 4'h1;
        step_and_expect("ch0_rise", 6, 4'h0, 4'h1, 4'h1, 4'h0);
        data_in = 4'h0;
        step_and_expect("ch0_fall", 6, 4'h1, 4'h0, 4'h0, 4'h1);

        // Ch1 high for 3 clocks only: must be rejected
        data_in = 4'h2;
        tick();
        tick();
        tick();
        data_in = 4'h0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_outs("glitch", 4'h0, 4'h0, 4'h0, 1'b0);
        end

        // Bounce 1,1,1,0,1,1,1,1 on ch1: flip on edge 10 only
        for (int k = 1; k <= 12; k++) begin
            data_in = (k <= 8) ? {2'b00, bounce[k-1], 1'b0} : 4'h2;
            tick();
            check_eq("bounce.level1", 32'(level_out[1]), 32'(k >= 10));
            check_eq("bounce.rise1",  32'(rise_out[1]),  32'(k == 10));
            check_eq("bounce.change", 32'(change_out),   32'(k == 10));
        end

        // Move to level 4'h4: ch1 falls and ch2 rises together
        data_in = 4'h4;
        step_and_expect("swap12", 6, 4'h2, 4'h4, 4'h4, 4'h2);

        // Ch0 rises while ch2 falls on the same edge
        data_in = 4'h1;
        step_and_expect("simul", 6, 4'h4, 4'h1, 4'h1, 4'h4);

        // Ch3 rise interrupted by reset after two filter counts
        data_in = 4'h9;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_outs("mid.pre", 4'h1, 4'h0, 4'h0, 1'b0);
        end
        reset_n = 1'b0;
        #2;
        check_outs("mid.async", 4'h0, 4'h0, 4'h0, 1'b0);
        tick();
        tick();
        check_outs("mid.held", 4'h0, 4'h0, 4'h0, 1'b0);
        reset_n = 1'b1;
        step_and_expect("mid.release", 6, 4'h0, 4'h9, 4'h9, 4'h0);

        // Swept instance: reset level 1, input held low through reset
        check_eq("p.reset.level", 32'(level_out1), 32'h0000000F);
        check_eq("p.reset.fall",  32'(fall_out1),  32'h0);
        rst1_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq("p.level",  32'(level_out1),  (k >= 4) ? 32'h0 : 32'hF);
            check_eq("p.fall",   32'(fall_out1),   (k == 4) ? 32'hF : 32'h0);
            check_eq("p.rise",   32'(rise_out1),   32'h0);
            check_eq("p.change", 32'(change_out1), 32'(k == 4));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
